// File: rtl/algo_fque_client.sv
// algo_fque_client
//   Consumer-side agent for the free-pointer queue. It prefetches free
//   pointers from the queue into a small local buffer, so that the client
//   does not see the queue's pop latency. It also collects released pointers
//   in a return FIFO and pushes them back to the queue.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   fq_ready, fq_freecnt   free queue initialised / current occupancy
//   pop                    pop request to the free queue
//   po_pvld, po_ptr        popped pointer, valid QPTR_DELAY cycles after pop
//   push, pu_ptr           pointer returned to the free queue
//   alloc_req/rdy/vld/ptr  allocate handshake (pointer arrives one cycle after the grant)
//   free_req/ptr/rdy       release handshake into the return FIFO
//   ready                  client initialised
//   flush, flush_done      only when ALGO_FQUE_CLIENT_FLUSH_EN is defined:
//                          return every held pointer to the queue, then report done
//
// Optional feature macro: ALGO_FQUE_CLIENT_FLUSH_EN
module algo_fque_client #(
    parameter int BITQPTR    = 4,
    parameter int BITQCNT    = 5,
    parameter int QPTR_DELAY = 2,
    parameter int PFDEPTH    = 4,
    parameter int BITPFD     = 2,
    parameter int RTDEPTH    = 4,
    parameter int BITRTD     = 2
) (
    input  logic               clk,
    input  logic               rst,
`ifdef ALGO_FQUE_CLIENT_FLUSH_EN
    input  logic               flush,
    output logic               flush_done,
`endif
    input  logic               fq_ready,
    input  logic [BITQCNT-1:0] fq_freecnt,
    output logic               pop,
    input  logic               po_pvld,
    input  logic [BITQPTR-1:0] po_ptr,
    output logic               push,
    output logic [BITQPTR-1:0] pu_ptr,
    input  logic               alloc_req,
    output logic               alloc_rdy,
    output logic               alloc_vld,
    output logic [BITQPTR-1:0] alloc_ptr,
    input  logic               free_req,
    input  logic [BITQPTR-1:0] free_ptr,
    output logic               free_rdy,
    output logic               ready
);

`ifdef ALGO_FQUE_CLIENT_FLUSH_EN
    typedef enum logic [2:0] {
        ST_INIT        = 3'd0,
        ST_RUN         = 3'd1,
        ST_FLUSH_WAIT  = 3'd2,
        ST_FLUSH_DRAIN = 3'd3,
        ST_FLUSHED     = 3'd4
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
`endif

    localparam logic [BITPFD:0]   PF_ONE  = (BITPFD+1)'(1);
    localparam logic [BITPFD-1:0] PFP_ONE = BITPFD'(1);
    localparam logic [BITRTD:0]   RT_ONE  = (BITRTD+1)'(1);
    localparam logic [BITRTD-1:0] RTP_ONE = BITRTD'(1);
    localparam logic [BITRTD:0]   RT_FULL = (BITRTD+1)'(RTDEPTH);

    // Number of pops still in flight towards the queue output.
    function automatic logic [7:0] pend_count(input logic [QPTR_DELAY-1:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < QPTR_DELAY; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [QPTR_DELAY-1:0]  pend_r, pend_nxt_s;
    logic [BITQPTR-1:0]     pf_mem_r [PFDEPTH];
    logic [BITPFD-1:0]      pf_wr_ptr_r, pf_rd_ptr_r;
    logic [BITPFD:0]        pf_cnt_r;
    logic [BITQPTR-1:0]     rt_mem_r [RTDEPTH];
    logic [BITRTD-1:0]      rt_wr_ptr_r, rt_rd_ptr_r;
    logic [BITRTD:0]        rt_cnt_r;
    logic                   alloc_vld_r;
    logic [BITQPTR-1:0]     alloc_ptr_r;

    logic                   run_s, drain_s, push_ok_s;
    logic [7:0]             pf_fill_s;
    logic                   pop_s, pf_empty_s, rt_empty_s;
    logic                   push_rt_s, push_pf_s, alloc_rdy_s, alloc_take_s;
    logic                   pf_wr_s, pf_rd_s, free_rdy_s, rt_wr_s;
    logic [BITQPTR-1:0]     pu_ptr_s;

    // Next-state decode and per-state enables.
    always_comb begin
        state_nxt_s = state_r;
        run_s       = 1'b0;
        drain_s     = 1'b0;
        push_ok_s   = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (fq_ready) state_nxt_s = ST_RUN;
                else          state_nxt_s = ST_INIT;
            end
            ST_RUN: begin
                run_s     = 1'b1;
                push_ok_s = 1'b1;
`ifdef ALGO_FQUE_CLIENT_FLUSH_EN
                if (flush) state_nxt_s = ST_FLUSH_WAIT;
                else       state_nxt_s = ST_RUN;
`else
                state_nxt_s = ST_RUN;
`endif
            end
`ifdef ALGO_FQUE_CLIENT_FLUSH_EN
            ST_FLUSH_WAIT: begin
                push_ok_s = 1'b1;
                // In-flight pops must land in the buffer before it can be drained.
                if (pend_r == {QPTR_DELAY{1'b0}}) state_nxt_s = ST_FLUSH_DRAIN;
                else                              state_nxt_s = ST_FLUSH_WAIT;
            end
            ST_FLUSH_DRAIN: begin
                drain_s   = 1'b1;
                push_ok_s = 1'b1;
                if (rt_empty_s && pf_empty_s) state_nxt_s = ST_FLUSHED;
                else                          state_nxt_s = ST_FLUSH_DRAIN;
            end
            ST_FLUSHED: begin
                if (!flush) state_nxt_s = ST_RUN;
                else        state_nxt_s = ST_FLUSHED;
            end
`endif
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // Handshake decode from registered state.
    always_comb begin
        pf_empty_s   = (pf_cnt_r == {(BITPFD+1){1'b0}});
        rt_empty_s   = (rt_cnt_r == {(BITRTD+1){1'b0}});
        // Count in-flight pops as occupied so the buffer can never overflow.
        pf_fill_s    = {{(7-BITPFD){1'b0}}, pf_cnt_r} + pend_count(pend_r);
        pop_s        = run_s && (fq_freecnt != {BITQCNT{1'b0}}) && (pf_fill_s < 8'(PFDEPTH));
        push_rt_s    = push_ok_s && !rt_empty_s;
        // While draining, the return FIFO has priority over the prefetch buffer.
        push_pf_s    = drain_s && rt_empty_s && !pf_empty_s;
        alloc_rdy_s  = !pf_empty_s && !drain_s;
        alloc_take_s = alloc_req && alloc_rdy_s;
        pf_wr_s      = pend_r[QPTR_DELAY-1] && po_pvld;
        pf_rd_s      = alloc_take_s || push_pf_s;
        free_rdy_s   = (rt_cnt_r != RT_FULL);
        rt_wr_s      = free_req && free_rdy_s;
        pend_nxt_s    = pend_r << 1;
        pend_nxt_s[0] = pop_s;
        if (push_pf_s) begin
            pu_ptr_s = pf_mem_r[pf_rd_ptr_r];
        end else if (push_rt_s) begin
            pu_ptr_s = rt_mem_r[rt_rd_ptr_r];
        end else begin
            pu_ptr_s = {BITQPTR{1'b0}};
        end
    end

    // State, pending-pop tracking, FIFO pointers/counters and allocate output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_INIT;
            pend_r      <= {QPTR_DELAY{1'b0}};
            pf_wr_ptr_r <= {BITPFD{1'b0}};
            pf_rd_ptr_r <= {BITPFD{1'b0}};
            pf_cnt_r    <= {(BITPFD+1){1'b0}};
            rt_wr_ptr_r <= {BITRTD{1'b0}};
            rt_rd_ptr_r <= {BITRTD{1'b0}};
            rt_cnt_r    <= {(BITRTD+1){1'b0}};
            alloc_vld_r <= 1'b0;
            alloc_ptr_r <= {BITQPTR{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            pend_r  <= pend_nxt_s;
            if (pf_wr_s) pf_wr_ptr_r <= pf_wr_ptr_r + PFP_ONE;
            if (pf_rd_s) pf_rd_ptr_r <= pf_rd_ptr_r + PFP_ONE;
            case ({pf_wr_s, pf_rd_s})
                2'b10:   pf_cnt_r <= pf_cnt_r + PF_ONE;
                2'b01:   pf_cnt_r <= pf_cnt_r - PF_ONE;
                default: pf_cnt_r <= pf_cnt_r;
            endcase
            if (rt_wr_s)   rt_wr_ptr_r <= rt_wr_ptr_r + RTP_ONE;
            if (push_rt_s) rt_rd_ptr_r <= rt_rd_ptr_r + RTP_ONE;
            case ({rt_wr_s, push_rt_s})
                2'b10:   rt_cnt_r <= rt_cnt_r + RT_ONE;
                2'b01:   rt_cnt_r <= rt_cnt_r - RT_ONE;
                default: rt_cnt_r <= rt_cnt_r;
            endcase
            alloc_vld_r <= alloc_take_s;
            if (alloc_take_s) alloc_ptr_r <= pf_mem_r[pf_rd_ptr_r];
        end
    end

    // Storage arrays; contents are don't-care while the counters say empty.
    always_ff @(posedge clk) begin
        if (pf_wr_s) pf_mem_r[pf_wr_ptr_r] <= po_ptr;
        if (rt_wr_s) rt_mem_r[rt_wr_ptr_r] <= free_ptr;
    end

    assign pop       = pop_s;
    assign push      = push_rt_s || push_pf_s;
    assign pu_ptr    = pu_ptr_s;
    assign alloc_rdy = alloc_rdy_s;
    assign alloc_vld = alloc_vld_r;
    assign alloc_ptr = alloc_ptr_r;
    assign free_rdy  = free_rdy_s;
    assign ready     = (state_r != ST_INIT);
`ifdef ALGO_FQUE_CLIENT_FLUSH_EN
    assign flush_done = (state_r == ST_FLUSHED);
`endif

endmodule

// File: tb/tb_algo_fque_client.sv
// Bench for algo_fque_client: a behavioural free-queue model answers pops
// after two cycles. Expected allocate pointers are queued when the model
// returns them, and expected push pointers are queued when frees are
// accepted. Both queues are popped as the DUT produces output.
module tb_algo_fque_client;
    localparam int BITQPTR = 4;
    localparam int BITQCNT = 5;
    localparam int PFDEPTH = 4;
    localparam int RTDEPTH = 4;

    logic               clk, rst, fq_ready, pop, po_pvld, push;
    logic               alloc_req, alloc_rdy, alloc_vld, free_req, free_rdy, ready;
    logic [BITQCNT-1:0] fq_freecnt;
    logic [BITQPTR-1:0] po_ptr, pu_ptr, alloc_ptr, free_ptr;

    typedef struct packed {
        logic       vld;
        logic [3:0] ptr;
        logic [7:0] ep;
    } resp_t;

    resp_t      pipe [2];
    resp_t      resp;
    logic [3:0] fq_q[$];
    logic [3:0] exp_alloc[$];
    logic [3:0] exp_push[$];
    logic [3:0] saved[$];
    int         checks_n, errors_n;

    logic       rst_v, fq_ready_v, alloc_req_v, free_req_v;
    logic [3:0] free_ptr_v;
    logic       fc_mode;
    logic [4:0] fc_force, freecnt_drv;

    logic       run_m, grant_prev;
    int         pf_m, rt_m;
    logic [1:0] pend_m;
    logic [7:0] epoch;
    logic [3:0] last_alloc;

    algo_fque_client dut (
        .clk(clk), .rst(rst), .fq_ready(fq_ready), .fq_freecnt(fq_freecnt),
        .pop(pop), .po_pvld(po_pvld), .po_ptr(po_ptr), .push(push), .pu_ptr(pu_ptr),
        .alloc_req(alloc_req), .alloc_rdy(alloc_rdy), .alloc_vld(alloc_vld),
        .alloc_ptr(alloc_ptr), .free_req(free_req), .free_ptr(free_ptr),
        .free_rdy(free_rdy), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fq_init();
        fq_q.delete();
        for (int i = 0; i < 16; i++) fq_q.push_back(4'(i));
    endtask

    // One clock cycle: drive inputs at negedge, check outputs 1ns later, advance the model.
    task automatic tick();
        logic       pop_e, push_e, grant, enq, wr;
        logic [3:0] e;
        @(negedge clk);
        resp    = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = '0;
        freecnt_drv = fc_mode ? fc_force : 5'(fq_q.size());
        rst        = rst_v;
        fq_ready   = fq_ready_v;
        fq_freecnt = freecnt_drv;
        po_pvld    = resp.vld;
        po_ptr     = resp.ptr;
        alloc_req  = alloc_req_v;
        free_req   = free_req_v;
        free_ptr   = free_ptr_v;
        if (resp.vld && (resp.ep == epoch) && !rst_v) exp_alloc.push_back(resp.ptr);
        #1;
        pop_e  = run_m && (freecnt_drv != 5'd0) &&
                 ((pf_m + int'(pend_m[0]) + int'(pend_m[1])) < PFDEPTH);
        push_e = run_m && (rt_m != 0);
        chk("ready", 32'(ready), 32'(run_m));
        chk("pop", 32'(pop), 32'(pop_e));
        chk("alloc_rdy", 32'(alloc_rdy), 32'(pf_m != 0));
        chk("alloc_vld", 32'(alloc_vld), 32'(grant_prev));
        chk("push", 32'(push), 32'(push_e));
        chk("free_rdy", 32'(free_rdy), 32'(rt_m != RTDEPTH));
        if (alloc_vld) begin
            chk("alloc_sb_avail", 32'(exp_alloc.size() != 0), 32'd1);
            if (exp_alloc.size() != 0) begin
                e = exp_alloc.pop_front();
                chk("alloc_ptr", 32'(alloc_ptr), 32'(e));
                last_alloc = e;
            end
        end else begin
            chk("alloc_hold", 32'(alloc_ptr), 32'(last_alloc));
        end
        if (push) begin
            chk("push_sb_avail", 32'(exp_push.size() != 0), 32'd1);
            if (exp_push.size() != 0) begin
                e = exp_push.pop_front();
                chk("pu_ptr", 32'(pu_ptr), 32'(e));
                fq_q.push_back(e);
            end
        end
        if (pop) begin
            if (fq_q.size() != 0) pipe[0] = '{vld: 1'b1, ptr: fq_q.pop_front(), ep: epoch};
            else                  pipe[0] = '{vld: 1'b0, ptr: 4'd0, ep: epoch};
        end
        grant = alloc_req_v && (pf_m != 0);
        enq   = free_req_v && (rt_m != RTDEPTH);
        wr    = pend_m[1] && resp.vld;
        if (rst_v) begin
            run_m = 1'b0; grant_prev = 1'b0; pf_m = 0; rt_m = 0; pend_m = 2'b00;
            last_alloc = 4'd0; epoch = epoch + 8'd1;
            exp_alloc.delete(); exp_push.delete(); fq_init();
        end else begin
            if (enq) exp_push.push_back(free_ptr_v);
            pf_m       = pf_m + int'(wr) - int'(grant);
            rt_m       = rt_m + int'(enq) - int'(push_e);
            pend_m     = {pend_m[0], pop_e};
            grant_prev = grant;
            if (fq_ready_v) run_m = 1'b1;
        end
    endtask

    initial begin
        checks_n = 0; errors_n = 0;
        rst = 1'b1; fq_ready = 1'b0; fq_freecnt = 5'd0; po_pvld = 1'b0; po_ptr = 4'd0;
        alloc_req = 1'b0; free_req = 1'b0; free_ptr = 4'd0;
        rst_v = 1'b1; fq_ready_v = 1'b0; alloc_req_v = 1'b0; free_req_v = 1'b0; free_ptr_v = 4'd0;
        fc_mode = 1'b0; fc_force = 5'd0;
        run_m = 1'b0; grant_prev = 1'b0; pf_m = 0; rt_m = 0; pend_m = 2'b00;
        epoch = 8'd0; last_alloc = 4'd0;
        pipe[0] = '0; pipe[1] = '0;
        fq_init();
        repeat (2) @(posedge clk);
        tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_alloc_vld", 32'(alloc_vld), 32'd0);
        chk("rst_alloc_ptr", 32'(alloc_ptr), 32'd0);
        rst_v = 1'b0;

        // Start-up: fq_ready at cycle 3, four prefetch pops at cycles 4..7.
        for (int c = 0; c < 12; c++) begin
            fq_ready_v = (c >= 3);
            tick();
            chk("ready_cyc", 32'(ready), 32'(c >= 4));
            chk("pop_win", 32'(pop), 32'(c >= 4 && c <= 7));
            chk("alloc_rdy_cyc", 32'(alloc_rdy), 32'(c >= 7));
        end

        // Steady state: continuous allocation with refill pops.
        alloc_req_v = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 1 && i <= 4) chk("alloc_b2b", 32'(alloc_vld), 32'd1);
        end
        alloc_req_v = 1'b0;
        repeat (6) tick();

        // Queue claims one entry but is empty on the second pop.
        fc_mode = 1'b1; fc_force = 5'd0; alloc_req_v = 1'b1;
        repeat (8) tick();
        alloc_req_v = 1'b0;
        repeat (2) tick();
        chk("drain_empty", 32'(alloc_rdy), 32'd0);
        saved = fq_q;
        fq_q.delete();
        fq_q.push_back(saved.pop_front());
        fc_force = 5'd1;
        repeat (2) tick();
        fc_force = 5'd0;
        repeat (3) tick();
        chk("stale_rdy", 32'(alloc_rdy), 32'd1);
        alloc_req_v = 1'b1;
        tick();
        alloc_req_v = 1'b0;
        tick();
        chk("single_vld", 32'(alloc_vld), 32'd1);
        chk("single_only", 32'(alloc_rdy), 32'd0);
        fq_q = saved;
        fc_mode = 1'b0;
        repeat (8) tick();

        // Back-to-back frees in RUN: each one pushed the following cycle.
        for (int i = 0; i < 5; i++) begin
            free_req_v = 1'b1; free_ptr_v = 4'(9 + i);
            tick();
            if (i >= 1) chk("push_b2b", 32'(push), 32'd1);
        end
        free_req_v = 1'b0;
        tick();
        chk("push_last", 32'(push), 32'd1);
        tick();
        chk("push_idle", 32'(push), 32'd0);

        // Reset with pointers buffered and pops in flight.
        alloc_req_v = 1'b1;
        repeat (2) tick();
        alloc_req_v = 1'b0;
        tick();
        rst_v = 1'b1; fq_ready_v = 1'b0;
        tick();
        rst_v = 1'b0;
        tick();
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_pop", 32'(pop), 32'd0);
        chk("mid_rst_push", 32'(push), 32'd0);
        chk("mid_rst_alloc_rdy", 32'(alloc_rdy), 32'd0);
        chk("mid_rst_alloc_ptr", 32'(alloc_ptr), 32'd0);
        alloc_req_v = 1'b1;
        tick();
        chk("stale_po_ignored", 32'(alloc_rdy), 32'd0);
        alloc_req_v = 1'b0;
        tick();
        chk("alloc_dropped", 32'(alloc_vld), 32'd0);

        // Frees while push is stalled in INIT: fifth one sees free_rdy=0.
        for (int i = 0; i < 5; i++) begin
            free_req_v = 1'b1; free_ptr_v = 4'(9 + i);
            tick();
            chk("free_rdy_seq", 32'(free_rdy), 32'(i < 4));
        end
        free_req_v = 1'b0;
        fq_ready_v = 1'b1;
        repeat (10) tick();
        chk("push_drained", 32'(exp_push.size()), 32'd0);
        chk("ready_final", 32'(ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end
endmodule
